rst_seq: RTL and testbench

RST_SEQ -- requirements
Module: rst_seq

---
 rtl/rst_pkg.sv | 20 ++
 rtl/rst_sync.sv | 20 ++
 rtl/rst_seq.sv | 126 ++++++++++++
 tb/tb_rst_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rst_pkg.sv
// Shared types for the reset sequencer: reset cause codes and sequencer states.
package rst_pkg;

    typedef enum logic [1:0] {
        POR = 2'd0,
        WDT = 2'd1,
        SW  = 2'd2
    } rst_cause_e;

    typedef enum logic [1:0] {
        HOLD,
        GAP,
        RUN
    } rst_state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts sys_rst as soon as rst rises, releases it
// only after STAGES rising clk edges with rst low.
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic sys_rst
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) chain <= '1;
        else     chain <= {chain[STAGES-2:0], 1'b0};
    end

    assign sys_rst = chain[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: holds both domain resets, releases the bus domain first,
// then the core domain, and re-enters the sequence on watchdog or software request.
module rst_seq
    import rst_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_rst_req,
    input  logic       wdt_expire,
    output logic       sw_rst_ack,
    output logic       bus_rst,
    output logic       core_rst,
    output logic       rst_done,
    output logic [1:0] rst_cause
);

    localparam int CW = $clog2(max2(HOLD_CYCLES, STAGE_GAP) + 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] GAP_LD  = CW'(STAGE_GAP);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic sys_rst;

    rst_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .sys_rst (sys_rst)
    );

    rst_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_q, bus_d;
    logic          core_q, core_d;
    logic          done_q, done_d;
    logic          ack_q, ack_d;
    rst_cause_e    cause_q, cause_d;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= HOLD;
            cnt_q   <= HOLD_LD;
            bus_q   <= 1'b1;
            core_q  <= 1'b1;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            cause_q <= POR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bus_q   <= bus_d;
            core_q  <= core_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            cause_q <= cause_d;
        end
    end

    // Counter loads on state entry and the state is left when it reads 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bus_d   = bus_q;
        core_d  = core_q;
        done_d  = done_q;
        ack_d   = 1'b0;
        cause_d = cause_q;
        case (state_q)
            HOLD: begin
                if (wdt_expire) begin
                    cnt_d   = HOLD_LD;
                    cause_d = WDT;
                end else if (cnt_q == ONE) begin
                    state_d = GAP;
                    cnt_d   = GAP_LD;
                    bus_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            GAP: begin
                if (wdt_expire) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                    bus_d   = 1'b1;
                    cause_d = WDT;
                end else if (cnt_q == ONE) begin
                    state_d = RUN;
                    core_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            RUN: begin
                if (wdt_expire || sw_rst_req) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                    bus_d   = 1'b1;
                    core_d  = 1'b1;
                    done_d  = 1'b0;
                    // Watchdog has priority; the held software request is served later.
                    cause_d = wdt_expire ? WDT : SW;
                    ack_d   = !wdt_expire;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = HOLD_LD;
                bus_d   = 1'b1;
                core_d  = 1'b1;
                done_d  = 1'b0;
            end
        endcase
    end

    assign sw_rst_ack = ack_q;
    assign bus_rst    = bus_q;
    assign core_rst   = core_q;
    assign rst_done   = done_q;
    assign rst_cause  = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: directed release-timing scenarios plus random watchdog,
// software and async-reset traffic against an elapsed-time reference model.
module tb_rst_seq;

    localparam int SYNC = 2;
    localparam int HOLD = 16;
    localparam int GAP  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic       wdt_expire = 1'b0;
    logic       sw_rst_ack, bus_rst, core_rst, rst_done;
    logic [1:0] rst_cause;

    always #5 clk = ~clk;

    rst_seq #(.SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_rst_req (sw_rst_req),
        .wdt_expire (wdt_expire),
        .sw_rst_ack (sw_rst_ack),
        .bus_rst    (bus_rst),
        .core_rst   (core_rst),
        .rst_done   (rst_done),
        .rst_cause  (rst_cause)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: edges seen since rst dropped, and cycles elapsed since the
    // current sequence started (t); outputs follow from t by plain comparison.
    int sync_edges = 0;
    int t          = 0;
    int cause_m    = 0;
    bit ack_m      = 1'b0;
    bit sw_pend    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit m_sys();
        return rst || (sync_edges < SYNC);
    endfunction

    task automatic check_outs(input string ph);
        bit in_rst;
        in_rst = m_sys();
        chk({ph, ".bus_rst"},  bus_rst,    in_rst ? 1 : (t < HOLD));
        chk({ph, ".core_rst"}, core_rst,   in_rst ? 1 : (t < HOLD + GAP));
        chk({ph, ".rst_done"}, rst_done,   in_rst ? 0 : (t >= HOLD + GAP));
        chk({ph, ".ack"},      sw_rst_ack, in_rst ? 0 : ack_m);
        chk({ph, ".cause"},    rst_cause,  in_rst ? 0 : cause_m);
    endtask

    task automatic model_edge();
        bit done_now;
        if (rst) begin
            sync_edges = 0;
        end else if (sync_edges < SYNC) begin
            sync_edges++;
            if (sync_edges == SYNC) begin
                t = 0; cause_m = 0; ack_m = 1'b0;
            end
        end else begin
            done_now = (t >= HOLD + GAP);
            ack_m = 1'b0;
            if (wdt_expire) begin
                t = 0; cause_m = 1;
            end else if (done_now && sw_rst_req) begin
                t = 0; cause_m = 2; ack_m = 1'b1;
            end else if (t < HOLD + GAP) begin
                t++;
            end
        end
    endtask

    // One clock: drive at the falling edge, advance the model at the rising
    // edge, compare at the next falling edge. The requester drops on ack.
    task automatic step(input bit w, input bit s);
        wdt_expire = w;
        if (s) sw_pend = 1'b1;
        sw_rst_req = sw_pend;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (ack_m) sw_pend = 1'b0;
        check_outs("step");
    endtask

    task automatic async_rst(input int hold_cyc);
        #2;
        rst = 1'b1;
        sync_edges = 0;
        #1;
        check_outs("async");
        repeat (hold_cyc) step(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic release_timing(input string tag);
        int e_bus, e_core;
        e_bus = -1;
        e_core = -1;
        for (int i = 1; i <= 40; i++) begin
            step(1'b0, 1'b0);
            if (e_bus < 0 && bus_rst === 1'b0) e_bus = i;
            if (e_core < 0 && core_rst === 1'b0) e_core = i;
        end
        chk({tag, ".bus_edges"},  e_bus,  SYNC + HOLD);
        chk({tag, ".core_edges"}, e_core, SYNC + HOLD + GAP);
        chk({tag, ".cause"},      rst_cause, 0);
    endtask

    task automatic run_until_done(input string tag, output int edges);
        edges = 0;
        while (rst_done !== 1'b1 && edges < 60) begin
            step(1'b0, 1'b0);
            edges++;
        end
        chk({tag, ".done_reached"}, rst_done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int e;
        #1 rst = 1'b1;
        @(negedge clk);
        check_outs("por_hold");
        repeat (3) step(1'b0, 1'b0);
        rst = 1'b0;
        release_timing("por");

        // Software request, dropped on ack.
        step(1'b0, 1'b1);
        chk("sw.ack", sw_rst_ack, 1);
        chk("sw.bus", bus_rst, 1);
        chk("sw.core", core_rst, 1);
        step(1'b0, 1'b0);
        chk("sw.ack_once", sw_rst_ack, 0);
        run_until_done("sw", e);
        chk("sw.edges", e + 1, HOLD + GAP);
        chk("sw.cause", rst_cause, 2);

        // Simultaneous watchdog and software request: watchdog wins.
        step(1'b1, 1'b1);
        chk("sim.ack", sw_rst_ack, 0);
        chk("sim.cause", rst_cause, 1);
        run_until_done("sim", e);
        step(1'b0, 1'b0);
        chk("sim.ack2", sw_rst_ack, 1);
        chk("sim.cause2", rst_cause, 2);
        run_until_done("sim2", e);

        // Watchdog in the second GAP cycle.
        step(1'b1, 1'b0);
        e = 0;
        while (bus_rst !== 1'b0 && e < 40) begin
            step(1'b0, 1'b0);
            e++;
        end
        chk("gap.entered", bus_rst, 0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("gap.bus", bus_rst, 1);
        chk("gap.core", core_rst, 1);
        run_until_done("gap", e);
        chk("gap.edges", e, HOLD + GAP);
        chk("gap.cause", rst_cause, 1);

        // Power-on reset in HOLD cycle 8.
        step(1'b1, 1'b0);
        repeat (7) step(1'b0, 1'b0);
        async_rst(2);
        release_timing("midpor");

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) < 4) begin
                async_rst($urandom_range(1, 3));
            end else begin
                step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
